// File: rtl/muldiv_unit.sv
// Integer multiply/divide unit for the RISC-V M extension: fixed-latency multiply,
// radix-2 restoring divide with single-cycle divide-by-zero and signed-overflow results.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | ready; accepts an op, special divides written back directly
// S_MUL      | multiply latency count, writeback on the last count
// S_DIV_ITER | one quotient bit per cycle on unsigned magnitudes
// S_DIV_FIX  | sign correction and quotient/remainder select, writeback
module muldiv_unit #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       opcode_i,
    input  logic [XLEN-1:0]  operand1_i,
    input  logic [XLEN-1:0]  operand2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             wb_valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] wb_tag_o
);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL      = 2'd1;
    localparam logic [1:0] S_DIV_ITER = 2'd2;
    localparam logic [1:0] S_DIV_FIX  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             sgn1_q, sgn1_d, sgn2_q, sgn2_d;
    logic [XLEN-1:0]  abs1_q, abs1_d, abs2_q, abs2_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic             wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

    logic            in_idle, accept, sgn1_in, sgn2_in, div_zero_in, ovf_in;
    logic [XLEN-1:0] abs1_in, abs2_in, special_res;
    logic [XLEN-1:0] m_a, m_b, mul_res, quo_fix, rem_fix;
    logic [1:0]      m_op;
    logic            m_neg;
    logic [2*XLEN-1:0] prod_u, prod_s;
    logic [XLEN:0]   trial, diff;

    assign in_idle = (state_q == S_IDLE);
    assign accept  = valid_i & in_idle & ~flush_i;

    always_comb begin
        sgn1_in = 1'b0;
        sgn2_in = 1'b0;
        if (opcode_i[2]) begin
            sgn1_in = ~opcode_i[0] & operand1_i[XLEN-1];
            sgn2_in = ~opcode_i[0] & operand2_i[XLEN-1];
        end else begin
            sgn1_in = ((opcode_i[1:0] == 2'b01) | (opcode_i[1:0] == 2'b10)) & operand1_i[XLEN-1];
            sgn2_in = (opcode_i[1:0] == 2'b01) & operand2_i[XLEN-1];
        end
    end

    assign abs1_in     = sgn1_in ? -operand1_i : operand1_i;
    assign abs2_in     = sgn2_in ? -operand2_i : operand2_i;
    assign div_zero_in = (operand2_i == '0);
    assign ovf_in      = ~opcode_i[0] & (operand1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&operand2_i);
    assign special_res = div_zero_in ? (opcode_i[1] ? operand1_i : '1)
                                     : (opcode_i[1] ? '0 : operand1_i);

    // One multiplier: fed from the inputs when a single-cycle multiply finishes from idle.
    assign m_a     = in_idle ? abs1_in : abs1_q;
    assign m_b     = in_idle ? abs2_in : abs2_q;
    assign m_neg   = in_idle ? (sgn1_in ^ sgn2_in) : (sgn1_q ^ sgn2_q);
    assign m_op    = in_idle ? opcode_i[1:0] : op_q;
    assign prod_u  = {{XLEN{1'b0}}, m_a} * {{XLEN{1'b0}}, m_b};
    assign prod_s  = m_neg ? -prod_u : prod_u;
    assign mul_res = (m_op == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    // abs1_q doubles as the dividend/quotient shift register during iteration.
    assign trial   = {rem_q, abs1_q[XLEN-1]};
    assign diff    = trial - {1'b0, abs2_q};
    assign quo_fix = (sgn1_q ^ sgn2_q) ? -abs1_q : abs1_q;
    assign rem_fix = sgn1_q ? -rem_q : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tag_d      = tag_q;
        sgn1_d     = sgn1_q;
        sgn2_d     = sgn2_q;
        abs1_d     = abs1_q;
        abs2_d     = abs2_q;
        rem_d      = rem_q;
        wb_valid_d = 1'b0;
        result_d   = result_q;
        wb_tag_d   = wb_tag_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = opcode_i[1:0];
                    tag_d  = tag_i;
                    sgn1_d = sgn1_in;
                    sgn2_d = sgn2_in;
                    abs1_d = abs1_in;
                    abs2_d = abs2_in;
                    rem_d  = '0;
                    cnt_d  = CNT_W'(1);
                    if (opcode_i[2]) begin
                        if (div_zero_in | ovf_in) begin
                            wb_valid_d = 1'b1;
                            result_d   = special_res;
                            wb_tag_d   = tag_i;
                            cnt_d      = '0;
                        end else begin
                            state_d = S_DIV_ITER;
                        end
                    end else if (MUL_LAT == 1) begin
                        wb_valid_d = 1'b1;
                        result_d   = mul_res;
                        wb_tag_d   = tag_i;
                        cnt_d      = '0;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == MUL_LAST) begin
                    wb_valid_d = 1'b1;
                    result_d   = mul_res;
                    wb_tag_d   = tag_q;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV_ITER: begin
                if (diff[XLEN]) begin
                    rem_d  = trial[XLEN-1:0];
                    abs1_d = {abs1_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d  = diff[XLEN-1:0];
                    abs1_d = {abs1_q[XLEN-2:0], 1'b1};
                end
                if (cnt_q == DIV_LAST) begin
                    state_d = S_DIV_FIX;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                wb_valid_d = 1'b1;
                result_d   = op_q[1] ? rem_fix : quo_fix;
                wb_tag_d   = tag_q;
                state_d    = S_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            sgn1_q     <= 1'b0;
            sgn2_q     <= 1'b0;
            abs1_q     <= '0;
            abs2_q     <= '0;
            rem_q      <= '0;
            wb_valid_q <= 1'b0;
            result_q   <= '0;
            wb_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            sgn1_q     <= sgn1_d;
            sgn2_q     <= sgn2_d;
            abs1_q     <= abs1_d;
            abs2_q     <= abs2_d;
            rem_q      <= rem_d;
            wb_valid_q <= wb_valid_d;
            result_q   <= result_d;
            wb_tag_q   <= wb_tag_d;
        end
    end

    assign ready_o    = in_idle;
    assign wb_valid_o = wb_valid_q;
    assign result_o   = result_q;
    assign wb_tag_o   = wb_tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32, TAG_W=6, MUL_LAT=2.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_i, flush_i, valid_i;
    logic        ready_o, wb_valid_o;
    logic [2:0]  opcode_i;
    logic [31:0] operand1_i, operand2_i, result_o;
    logic [5:0]  tag_i, wb_tag_o;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
                           OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    muldiv_unit #(.XLEN(32), .TAG_W(6), .MUL_LAT(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .operand1_i(operand1_i), .operand2_i(operand2_i), .tag_i(tag_i),
        .wb_valid_o(wb_valid_o), .result_o(result_o), .wb_tag_o(wb_tag_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one op in the current cycle (cycle 0), scrambles the inputs while busy,
    // then checks latency, result, tag and ready behaviour.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tg, input logic [31:0] exp_res, input int exp_lat,
                          input string name);
        int cyc;
        logic rdy_ok;
        chk({name, " ready0"}, {31'd0, ready_o}, 32'd1);
        opcode_i = op; operand1_i = a; operand2_i = b; tag_i = tg; valid_i = 1'b1;
        tick();
        valid_i = 1'b0; opcode_i = ~op; operand1_i = $urandom; operand2_i = $urandom; tag_i = ~tg;
        cyc = 1;
        rdy_ok = 1'b1;
        while (wb_valid_o !== 1'b1 && cyc < 100) begin
            if (ready_o !== 1'b0) rdy_ok = 1'b0;
            tick();
            cyc++;
        end
        chk({name, " lat"}, cyc, exp_lat);
        chk({name, " res"}, result_o, exp_res);
        chk({name, " tag"}, {26'd0, wb_tag_o}, {26'd0, tg});
        chk({name, " busy"}, {31'd0, rdy_ok}, 32'd1);
        chk({name, " wbready"}, {31'd0, ready_o}, 32'd1);
    endtask

    task automatic quiet(input int n, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (wb_valid_o !== 1'b0) seen = 1'b1;
            tick();
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0;
        opcode_i = '0; operand1_i = '0; operand2_i = '0; tag_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("rst ready", {31'd0, ready_o}, 32'd1);
        chk("rst wb", {31'd0, wb_valid_o}, 32'd0);
        chk("rst res", result_o, 32'd0);
        chk("rst tag", {26'd0, wb_tag_o}, 32'd0);

        run_op(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 6'd5, 32'h00000000, 2, "mulh");
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 6'd6, 32'hFFFFFFFE, 2, "mulhu");
        run_op(OP_MUL,    32'd7,        32'd6,        6'd1, 32'd42,       2, "mul");
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        6'd2, 32'hFFFFFFFF, 2, "mulhsu");
        run_op(OP_MUL,    32'h80000000, 32'hFFFFFFFF, 6'd3, 32'h80000000, 2, "mul_neg");

        // result and tag hold after the strobe
        tick();
        chk("hold wb", {31'd0, wb_valid_o}, 32'd0);
        chk("hold res", result_o, 32'h80000000);
        chk("hold tag", {26'd0, wb_tag_o}, 32'd3);

        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 6'd10, 32'hFFFFFFFD, 34, "div");
        run_op(OP_REM,  32'hFFFFFFF9, 32'd2, 6'd11, 32'hFFFFFFFF, 34, "rem");
        run_op(OP_DIVU, 32'd100,      32'd7, 6'd12, 32'd14,       34, "divu");
        run_op(OP_REMU, 32'd100,      32'd7, 6'd13, 32'd2,        34, "remu");
        run_op(OP_DIV,  32'd100,      32'hFFFFFFF9, 6'd14, 32'hFFFFFFF2, 34, "div_negd");
        // back-to-back: accepted in the previous writeback cycle
        run_op(OP_MUL,  32'd3,        32'd5, 6'd15, 32'd15,       2,  "b2b mul");

        run_op(OP_DIV,  32'h1234,     32'd0, 6'd20, 32'hFFFFFFFF, 1, "div0");
        run_op(OP_REMU, 32'h1234,     32'd0, 6'd21, 32'h1234,     1, "remu0");
        run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 6'd22, 32'h80000000, 1, "div ovf");
        run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 6'd23, 32'h00000000, 1, "rem ovf");
        run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 6'd24, 32'h00000000, 34, "divu noovf");

        // flush at cycle 10 of a divide
        opcode_i = OP_DIVU; operand1_i = 32'd1000; operand2_i = 32'd3; tag_i = 6'd30; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush ready", {31'd0, ready_o}, 32'd1);
        chk("flush wb", {31'd0, wb_valid_o}, 32'd0);
        quiet(40, "flush nowb");

        // accept coinciding with flush is dropped
        opcode_i = OP_MUL; operand1_i = 32'd9; operand2_i = 32'd9; tag_i = 6'd31;
        valid_i = 1'b1; flush_i = 1'b1;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flushacc ready", {31'd0, ready_o}, 32'd1);
        quiet(6, "flushacc nowb");

        run_op(OP_MULHU, 32'h00010000, 32'h00010000, 6'd33, 32'd1, 2, "post flush");

        // reset mid-multiply
        opcode_i = OP_MUL; operand1_i = 32'd11; operand2_i = 32'd11; tag_i = 6'd7; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstmul wb", {31'd0, wb_valid_o}, 32'd0);
        chk("rstmul res", result_o, 32'd0);
        chk("rstmul tag", {26'd0, wb_tag_o}, 32'd0);
        chk("rstmul ready", {31'd0, ready_o}, 32'd1);
        quiet(4, "rstmul nowb");

        // reset together with flush behaves as reset
        run_op(OP_MUL, 32'd4, 32'd4, 6'd8, 32'd16, 2, "pre rst");
        opcode_i = OP_DIV; operand1_i = 32'd50; operand2_i = 32'd5; tag_i = 6'd9; valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b1; flush_i = 1'b1;
        tick();
        rst_i = 1'b0; flush_i = 1'b0;
        chk("rstfl res", result_o, 32'd0);
        chk("rstfl tag", {26'd0, wb_tag_o}, 32'd0);
        chk("rstfl ready", {31'd0, ready_o}, 32'd1);
        quiet(40, "rstfl nowb");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
